// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor. Holds msip, the 64-bit mtimecmp
// compare register and the free-running 64-bit mtime. These are exposed as a
// memory-mapped responder on the core's valid/ready data bus.
//
// Ports
//   clk, rst      clock; synchronous active-low reset
//   mem_valid     request valid, held by requester until mem_ready
//   mem_addr      16-bit byte offset in the CLINT window ([1:0] ignored)
//   mem_wdata     write data
//   mem_wstrb     byte write strobes, 0000 = read
//   mem_rdata     read data, zero unless mem_ready
//   mem_ready     one-cycle response pulse, one cycle after acceptance
//   msip          software interrupt pending (bit0 of msip register)
//   mtip          timer interrupt pending, registered (mtime >= mtimecmp)
//   mtime         current mtime value
//
// Register map (word offsets)
//   0x0000 msip   0x4000/0x4004 mtimecmp lo/hi   0xBFF8/0xBFFC mtime lo/hi
module clint_timer #(
  parameter int unsigned RTC_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        msip,
  output logic        mtip,
  output logic [63:0] mtime
);

  localparam int PW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtime_nxt, mtimecmp_nxt;
  logic          msip_reg;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_val;
  logic          wr;
  logic          sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  // Byte-lane merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Word-address decode on the live request; the write happens at the
  // accepting edge, so no separate capture of addr/wdata is needed.
  assign sel_msip   = (mem_addr[15:2] == 14'h0000);
  assign sel_cmp_lo = (mem_addr[15:2] == 14'h1000);
  assign sel_cmp_hi = (mem_addr[15:2] == 14'h1001);
  assign sel_mt_lo  = (mem_addr[15:2] == 14'h2FFE);
  assign sel_mt_hi  = (mem_addr[15:2] == 14'h2FFF);

  // Bus FSM: IDLE accepts, RESP pulses mem_ready and ignores mem_valid.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (mem_valid) begin
        accept    = 1'b1;
        state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr = accept && (mem_wstrb != 4'b0000);

  // Read value is taken from the registers before this edge's tick/write.
  always_comb begin
    rd_val = 32'h0;
    if (sel_msip)   rd_val = {31'h0, msip_reg};
    if (sel_cmp_lo) rd_val = mtimecmp[31:0];
    if (sel_cmp_hi) rd_val = mtimecmp[63:32];
    if (sel_mt_lo)  rd_val = mtime[31:0];
    if (sel_mt_hi)  rd_val = mtime[63:32];
  end

  assign tick = (presc == PW'(RTC_DIV - 1));

  // A bus write to either mtime half wins over the tick: the written half
  // takes the merged data, the other half keeps its pre-tick value, and
  // that cycle's increment is dropped.
  always_comb begin
    mtime_nxt    = mtime + 64'(tick);
    mtimecmp_nxt = mtimecmp;
    if (wr && sel_mt_lo)
      mtime_nxt = {mtime[63:32], merge(mtime[31:0], mem_wdata, mem_wstrb)};
    if (wr && sel_mt_hi)
      mtime_nxt = {merge(mtime[63:32], mem_wdata, mem_wstrb), mtime[31:0]};
    if (wr && sel_cmp_lo)
      mtimecmp_nxt[31:0] = merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
    if (wr && sel_cmp_hi)
      mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], mem_wdata, mem_wstrb);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      mtime    <= 64'h0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_reg <= 1'b0;
      mtip     <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state    <= state_nxt;
      presc    <= tick ? '0 : presc + PW'(1);
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      // Compare uses current register values, so mtip lags by one cycle.
      mtip     <= (mtime >= mtimecmp);
      if (wr && sel_msip && mem_wstrb[0]) msip_reg <= mem_wdata[0];
      if (accept) rdata_q <= rd_val;
    end
  end

  assign mem_ready = (state == RESP);
  assign mem_rdata = mem_ready ? rdata_q : 32'h0;
  assign msip      = msip_reg;

endmodule
